mips_control_fsm: RTL and testbench

MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

---
 rtl/mips_control_fsm_if.sv | 34 +++
 rtl/mips_control_fsm.sv | 154 +++++++++++++++
 tb/tb_mips_control_fsm.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/mips_control_fsm_if.sv
// Control-path bundle between the multicycle MIPS controller and its datapath/memory.
// master = controller side, slave = datapath/memory side.
interface mips_control_fsm_if;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        zero;
    logic        neg;
    logic        grt;
    logic        eq;
    logic [4:0]  alu_op;
    logic        alu_src_imm;
    logic [15:0] ir;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src_branch;
    logic        mem_req;
    logic        mem_we;
    logic        reg_we;
    logic        wb_from_mem;
    logic [2:0]  state;
    logic        illegal;

    modport master (
        input  mem_data, mem_ready, zero, neg, grt, eq,
        output alu_op, alu_src_imm, ir, ir_write, pc_write, pc_src_branch,
               mem_req, mem_we, reg_we, wb_from_mem, state, illegal
    );

    modport slave (
        output mem_data, mem_ready, zero, neg, grt, eq,
        input  alu_op, alu_src_imm, ir, ir_write, pc_write, pc_src_branch,
               mem_req, mem_we, reg_we, wb_from_mem, state, illegal
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS-style control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing.
// Latency: 3 cycles (CMP/branch/JMP), 4 (ALU, SW), 5 (LW) with memory always ready.
// Backpressure: FETCH and MEM hold with mem_req asserted until mem_ready.
module mips_control_fsm #(
    parameter int DATA_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_control_fsm_if.master bus
);
    // The controller never touches datapath words; the width is carried for the datapath only.
    localparam int unused_data_width = DATA_WIDTH;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LUI  = 4'h2;
    localparam logic [3:0] OP_LLI  = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_CMP  = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BGT  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_LUI = 5'd12;
    localparam logic [4:0] ALU_LLI = 5'd13;
    localparam logic [4:0] ALU_CMP = 5'd14;

    state_t      state_q, state_d;
    logic [15:0] ir_q;
    logic [3:0]  flags_q;   // {zero, neg, grt, eq} captured on CMP
    logic        run_q;     // low until the first clock after reset release
    logic [3:0]  opcode;
    logic        op_illegal;
    logic        unused_flags;

    logic [4:0]  alu_op;
    logic        alu_src_imm, ir_write, pc_write, pc_src_branch;
    logic        mem_req, mem_we, reg_we, wb_from_mem, illegal, taken;

    assign opcode       = ir_q[15:12];
    assign op_illegal   = (opcode inside {4'hB, 4'hC, 4'hD, 4'hE}) ||
                          (opcode == OP_R && ir_q[3:0] == 4'hF);
    assign unused_flags = ^flags_q[3:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            ir_q    <= '0;
            flags_q <= '0;
            run_q   <= 1'b0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            if (ir_write)
                ir_q <= bus.mem_data;
            if (state_q == EXEC && opcode == OP_CMP)
                flags_q <= {bus.zero, bus.neg, bus.grt, bus.eq};
        end
    end

    always_comb begin
        state_d       = state_q;
        alu_op        = ALU_ADD;
        alu_src_imm   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src_branch = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        reg_we        = 1'b0;
        wb_from_mem   = 1'b0;
        illegal       = 1'b0;
        taken         = 1'b0;
        case (state_q)
            FETCH: begin
                if (run_q) begin
                    mem_req = 1'b1;
                    if (bus.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = DECODE;
                    end
                end
            end
            DECODE: begin
                if (op_illegal) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else if (opcode == OP_HALT) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_R:    begin alu_op = {1'b0, ir_q[3:0]}; state_d = WB; end
                    OP_ADDI: begin alu_src_imm = 1'b1; state_d = WB; end
                    OP_LUI:  begin alu_op = ALU_LUI; alu_src_imm = 1'b1; state_d = WB; end
                    OP_LLI:  begin alu_op = ALU_LLI; alu_src_imm = 1'b1; state_d = WB; end
                    OP_LW, OP_SW: begin alu_src_imm = 1'b1; state_d = MEM; end
                    OP_CMP:  alu_op = ALU_CMP;
                    OP_BEQ:  taken = flags_q[0];
                    OP_BGT:  taken = flags_q[1];
                    OP_BNE:  taken = !flags_q[0];
                    OP_JMP:  taken = 1'b1;
                    default: ;
                endcase
                pc_write      = taken;
                pc_src_branch = taken;
            end
            MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode == OP_SW);
                if (bus.mem_ready)
                    state_d = (opcode == OP_LW) ? WB : FETCH;
            end
            WB: begin
                reg_we      = 1'b1;
                wb_from_mem = (opcode == OP_LW);
                state_d     = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase
    end

    assign bus.alu_op        = alu_op;
    assign bus.alu_src_imm   = alu_src_imm;
    assign bus.ir            = ir_q;
    assign bus.ir_write      = ir_write;
    assign bus.pc_write      = pc_write;
    assign bus.pc_src_branch = pc_src_branch;
    assign bus.mem_req       = mem_req;
    assign bus.mem_we        = mem_we;
    assign bus.reg_we        = reg_we;
    assign bus.wb_from_mem   = wb_from_mem;
    assign bus.state         = state_q;
    assign bus.illegal       = illegal;
endmodule

// File: tb/tb_mips_control_fsm.sv
// Directed bench for mips_control_fsm: per-cycle expected observations go through a scoreboard queue.
module tb_mips_control_fsm;
    localparam logic [8:0] IRW = 9'h100, PCW = 9'h080, PCB = 9'h040, MRQ = 9'h020, MWE = 9'h010;
    localparam logic [8:0] RWE = 9'h008, WFM = 9'h004, ILL = 9'h002, IMM = 9'h001, NONE = 9'h000;
    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    typedef struct {
        string       tag;
        logic [32:0] obs;   // {state, alu_op, strobes, ir}
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [15:0] cur_ir;
    int          n_checks;
    int          n_fails;
    exp_t        sbq[$];

    mips_control_fsm_if bus ();

    mips_control_fsm #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_front();
        exp_t        e;
        logic [32:0] obs;
        e   = sbq.pop_front();
        obs = {bus.state, bus.alu_op,
               bus.ir_write, bus.pc_write, bus.pc_src_branch, bus.mem_req, bus.mem_we,
               bus.reg_we, bus.wb_from_mem, bus.illegal, bus.alu_src_imm, bus.ir};
        n_checks++;
        assert (obs === e.obs) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.obs);
        end
    endtask

    // Drive one cycle of inputs, queue the expected outputs, compare at the falling edge.
    task automatic cyc(input string tag, input logic rdy, input logic [15:0] d, input logic [3:0] fl,
                       input logic [2:0] st, input logic [4:0] aop, input logic [8:0] stb);
        exp_t e;
        bus.mem_ready = rdy;
        bus.mem_data  = d;
        {bus.zero, bus.neg, bus.grt, bus.eq} = fl;
        e.tag = tag;
        e.obs = {st, aop, stb, cur_ir};
        sbq.push_back(e);
        @(negedge clk);
        check_front();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_dec(input string tag, input logic [15:0] instr, input logic [8:0] dec_stb);
        cyc({tag, "_F"}, 1'b1, instr, 4'h0, S_F, 5'd0, MRQ | IRW | PCW);
        cur_ir = instr;
        cyc({tag, "_D"}, 1'b1, instr, 4'h0, S_D, 5'd0, dec_stb);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        cur_ir   = 16'h0000;
        rst_n    = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_data  = 16'h0000;
        {bus.zero, bus.neg, bus.grt, bus.eq} = 4'h0;

        // Reset holds everything idle even with mem_ready and flags high
        cyc("rst", 1'b1, 16'h1234, 4'hF, S_F, 5'd0, NONE);
        rst_n = 1'b1;
        cyc("rel", 1'b1, 16'h1234, 4'h0, S_F, 5'd0, NONE);

        fetch_dec("add", 16'h0120, NONE);
        cyc("add_E", 1'b1, 16'h0120, 4'h0, S_E, 5'd0, NONE);
        cyc("add_W", 1'b1, 16'h0120, 4'h0, S_W, 5'd0, RWE);

        fetch_dec("sra", 16'h012B, NONE);
        cyc("sra_E", 1'b1, 16'h012B, 4'h0, S_E, 5'd11, NONE);
        cyc("sra_W", 1'b1, 16'h012B, 4'h0, S_W, 5'd0, RWE);

        fetch_dec("addi", 16'h1105, NONE);
        cyc("addi_E", 1'b1, 16'h1105, 4'h0, S_E, 5'd0, IMM);
        cyc("addi_W", 1'b1, 16'h1105, 4'h0, S_W, 5'd0, RWE);

        fetch_dec("lui", 16'h2A12, NONE);
        cyc("lui_E", 1'b1, 16'h2A12, 4'h0, S_E, 5'd12, IMM);
        cyc("lui_W", 1'b1, 16'h2A12, 4'h0, S_W, 5'd0, RWE);

        fetch_dec("lli", 16'h3034, NONE);
        cyc("lli_E", 1'b1, 16'h3034, 4'h0, S_E, 5'd13, IMM);
        cyc("lli_W", 1'b1, 16'h3034, 4'h0, S_W, 5'd0, RWE);

        fetch_dec("lw", 16'h4105, NONE);
        cyc("lw_E", 1'b1, 16'h4105, 4'h0, S_E, 5'd0, IMM);
        for (int i = 0; i < 3; i++)
            cyc("lw_Mwait", 1'b0, 16'h4105, 4'h0, S_M, 5'd0, MRQ);
        cyc("lw_M", 1'b1, 16'h4105, 4'h0, S_M, 5'd0, MRQ);
        cyc("lw_W", 1'b1, 16'h4105, 4'h0, S_W, 5'd0, RWE | WFM);

        fetch_dec("sw", 16'h5208, NONE);
        cyc("sw_E", 1'b1, 16'h5208, 4'h0, S_E, 5'd0, IMM);
        cyc("sw_M", 1'b1, 16'h5208, 4'h0, S_M, 5'd0, MRQ | MWE);

        // eq latched by CMP must survive an unrelated instruction
        fetch_dec("cmp1", 16'h6012, NONE);
        cyc("cmp1_E", 1'b1, 16'h6012, 4'b0001, S_E, 5'd14, NONE);
        fetch_dec("addi2", 16'h1101, NONE);
        cyc("addi2_E", 1'b1, 16'h1101, 4'b0000, S_E, 5'd0, IMM);
        cyc("addi2_W", 1'b1, 16'h1101, 4'b0000, S_W, 5'd0, RWE);
        fetch_dec("beq1", 16'h7003, NONE);
        cyc("beq1_E", 1'b1, 16'h7003, 4'b0000, S_E, 5'd0, PCW | PCB);

        fetch_dec("cmp2", 16'h6012, NONE);
        cyc("cmp2_E", 1'b1, 16'h6012, 4'b0010, S_E, 5'd14, NONE);
        fetch_dec("beq2", 16'h7003, NONE);
        cyc("beq2_E", 1'b1, 16'h7003, 4'b0001, S_E, 5'd0, NONE);
        fetch_dec("bgt", 16'h8003, NONE);
        cyc("bgt_E", 1'b1, 16'h8003, 4'b0000, S_E, 5'd0, PCW | PCB);
        fetch_dec("bne", 16'h9003, NONE);
        cyc("bne_E", 1'b1, 16'h9003, 4'b0001, S_E, 5'd0, PCW | PCB);
        fetch_dec("jmp", 16'hA010, NONE);
        cyc("jmp_E", 1'b1, 16'hA010, 4'h0, S_E, 5'd0, PCW | PCB);

        fetch_dec("ill", 16'hB000, ILL);
        cyc("ill_next", 1'b0, 16'hB000, 4'h0, S_F, 5'd0, MRQ);
        fetch_dec("ill2", 16'h000F, ILL);
        cyc("ill2_next", 1'b0, 16'h000F, 4'h0, S_F, 5'd0, MRQ);

        // Asynchronous abort of a pending store
        fetch_dec("sw2", 16'h5208, NONE);
        cyc("sw2_E", 1'b1, 16'h5208, 4'h0, S_E, 5'd0, IMM);
        cyc("sw2_M", 1'b0, 16'h5208, 4'h0, S_M, 5'd0, MRQ | MWE);
        rst_n  = 1'b0;
        cur_ir = 16'h0000;
        cyc("sw2_rst", 1'b0, 16'h5208, 4'h0, S_F, 5'd0, NONE);
        cyc("sw2_rst2", 1'b1, 16'h5208, 4'h0, S_F, 5'd0, NONE);
        rst_n = 1'b1;
        cyc("rel2", 1'b1, 16'hF000, 4'h0, S_F, 5'd0, NONE);

        // Fresh reset clears flags: BNE is taken on eq=0
        fetch_dec("bne2", 16'h9003, NONE);
        cyc("bne2_E", 1'b1, 16'h9003, 4'b1111, S_E, 5'd0, PCW | PCB);

        fetch_dec("halt", 16'hF000, NONE);
        for (int i = 0; i < 20; i++)
            cyc("halt_H", logic'(i % 2), 16'h0120, 4'(i), S_H, 5'd0, NONE);
        rst_n  = 1'b0;
        cur_ir = 16'h0000;
        cyc("halt_rst", 1'b1, 16'h0120, 4'h0, S_F, 5'd0, NONE);
        rst_n = 1'b1;
        cyc("rel3", 1'b0, 16'h0120, 4'h0, S_F, 5'd0, NONE);
        cyc("refetch", 1'b0, 16'h0120, 4'h0, S_F, 5'd0, MRQ);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
